id_ex_stage_reg: RTL

- ID/EX pipeline register of the 5-stage MIPS core, directly downstream of the register file's read ports.
- Captures the decoded instruction, both register read operands and the control bundle each cycle.
- Sign-extends the immediate and resolves the destination register.
- Detects load-use hazards, inserting bubbles into EX while holding ID/IF. Handles flush and downstream stall, and keeps a saturating bubble counter.

---
 rtl/id_ex_stage_reg.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures the decoded instruction, operands and controls,
// detects load-use hazards and counts bubbles. Optional WB bypass via ID_WB_BYPASS_EN.
module id_ex_stage_reg #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [DW-1:0]    id_pc,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic [AW-1:0]    id_rd,
    input  logic [DW-1:0]    id_rs_data,
    input  logic [DW-1:0]    id_rt_data,
    input  logic [15:0]      id_imm,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_alu_src,
    input  logic             id_reg_dst,
    input  logic [3:0]       id_alu_op,
    input  logic             wb_reg_write,
    input  logic [AW-1:0]    wb_rd,
    input  logic [DW-1:0]    wb_data,
    input  logic             flush,
    input  logic             ex_stall,
    output logic             id_hold,
    output logic             hazard_stall,
    output logic             ex_valid,
    output logic [DW-1:0]    ex_pc,
    output logic [AW-1:0]    ex_rs,
    output logic [AW-1:0]    ex_rt,
    output logic [AW-1:0]    ex_dst,
    output logic [DW-1:0]    ex_rs_data,
    output logic [DW-1:0]    ex_rt_data,
    output logic [DW-1:0]    ex_imm,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_alu_src,
    output logic [3:0]       ex_alu_op,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic             ex_valid_q, ex_valid_d;
    logic [DW-1:0]    ex_pc_q, ex_pc_d;
    logic [AW-1:0]    ex_rs_q, ex_rs_d;
    logic [AW-1:0]    ex_rt_q, ex_rt_d;
    logic [AW-1:0]    ex_dst_q, ex_dst_d;
    logic [DW-1:0]    ex_rs_data_q, ex_rs_data_d;
    logic [DW-1:0]    ex_rt_data_q, ex_rt_data_d;
    logic [DW-1:0]    ex_imm_q, ex_imm_d;
    logic             ex_reg_write_q, ex_reg_write_d;
    logic             ex_mem_read_q, ex_mem_read_d;
    logic             ex_mem_write_q, ex_mem_write_d;
    logic             ex_mem_to_reg_q, ex_mem_to_reg_d;
    logic             ex_alu_src_q, ex_alu_src_d;
    logic [3:0]       ex_alu_op_q, ex_alu_op_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic [DW-1:0]    rs_data_sel;
    logic [DW-1:0]    rt_data_sel;
    logic             dst_match;

`ifdef ID_WB_BYPASS_EN
    // A same-cycle register file write is not yet visible on the read ports.
    always_comb begin
        rs_data_sel = id_rs_data;
        rt_data_sel = id_rt_data;
        if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs)) rs_data_sel = wb_data;
        if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rt)) rt_data_sel = wb_data;
    end
`else
    logic unused_wb;
    assign unused_wb   = ^{wb_reg_write, wb_rd, wb_data};
    assign rs_data_sel = id_rs_data;
    assign rt_data_sel = id_rt_data;
`endif

    // Hold protocol: id_hold=1 means IF/ID must keep its instruction; EX accepts
    // a new entry on any edge where ex_stall=0 (a bubble when flushed or hazarded).
    assign dst_match    = (ex_dst_q == id_rs) || (id_uses_rt && (ex_dst_q == id_rt));
    assign hazard_stall = id_valid && !flush && ex_valid_q && ex_mem_read_q
                          && (ex_dst_q != '0) && dst_match;
    assign id_hold      = hazard_stall || ex_stall;

    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_pc_d         = ex_pc_q;
        ex_rs_d         = ex_rs_q;
        ex_rt_d         = ex_rt_q;
        ex_dst_d        = ex_dst_q;
        ex_rs_data_d    = ex_rs_data_q;
        ex_rt_data_d    = ex_rt_data_q;
        ex_imm_d        = ex_imm_q;
        ex_reg_write_d  = ex_reg_write_q;
        ex_mem_read_d   = ex_mem_read_q;
        ex_mem_write_d  = ex_mem_write_q;
        ex_mem_to_reg_d = ex_mem_to_reg_q;
        ex_alu_src_d    = ex_alu_src_q;
        ex_alu_op_d     = ex_alu_op_q;
        bubble_cnt_d    = bubble_cnt_q;
        if (ex_stall) begin
            bubble_cnt_d = bubble_cnt_q;
        end else if (flush || hazard_stall) begin
            ex_valid_d      = 1'b0;
            ex_pc_d         = '0;
            ex_rs_d         = '0;
            ex_rt_d         = '0;
            ex_dst_d        = '0;
            ex_rs_data_d    = '0;
            ex_rt_data_d    = '0;
            ex_imm_d        = '0;
            ex_reg_write_d  = 1'b0;
            ex_mem_read_d   = 1'b0;
            ex_mem_write_d  = 1'b0;
            ex_mem_to_reg_d = 1'b0;
            ex_alu_src_d    = 1'b0;
            ex_alu_op_d     = '0;
            if (hazard_stall && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 1'b1;
        end else begin
            ex_valid_d      = id_valid;
            ex_pc_d         = id_pc;
            ex_rs_d         = id_rs;
            ex_rt_d         = id_rt;
            ex_dst_d        = id_reg_dst ? id_rd : id_rt;
            ex_rs_data_d    = rs_data_sel;
            ex_rt_data_d    = rt_data_sel;
            ex_imm_d        = {{(DW-16){id_imm[15]}}, id_imm};
            ex_reg_write_d  = id_valid && id_reg_write;
            ex_mem_read_d   = id_valid && id_mem_read;
            ex_mem_write_d  = id_valid && id_mem_write;
            ex_mem_to_reg_d = id_valid && id_mem_to_reg;
            ex_alu_src_d    = id_valid && id_alu_src;
            ex_alu_op_d     = id_valid ? id_alu_op : 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q      <= 1'b0;
            ex_pc_q         <= '0;
            ex_rs_q         <= '0;
            ex_rt_q         <= '0;
            ex_dst_q        <= '0;
            ex_rs_data_q    <= '0;
            ex_rt_data_q    <= '0;
            ex_imm_q        <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
            ex_alu_src_q    <= 1'b0;
            ex_alu_op_q     <= '0;
            bubble_cnt_q    <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_pc_q         <= ex_pc_d;
            ex_rs_q         <= ex_rs_d;
            ex_rt_q         <= ex_rt_d;
            ex_dst_q        <= ex_dst_d;
            ex_rs_data_q    <= ex_rs_data_d;
            ex_rt_data_q    <= ex_rt_data_d;
            ex_imm_q        <= ex_imm_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_mem_to_reg_q <= ex_mem_to_reg_d;
            ex_alu_src_q    <= ex_alu_src_d;
            ex_alu_op_q     <= ex_alu_op_d;
            bubble_cnt_q    <= bubble_cnt_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc         = ex_pc_q;
    assign ex_rs         = ex_rs_q;
    assign ex_rt         = ex_rt_q;
    assign ex_dst        = ex_dst_q;
    assign ex_rs_data    = ex_rs_data_q;
    assign ex_rt_data    = ex_rt_data_q;
    assign ex_imm        = ex_imm_q;
    assign ex_reg_write  = ex_reg_write_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign ex_mem_write  = ex_mem_write_q;
    assign ex_mem_to_reg = ex_mem_to_reg_q;
    assign ex_alu_src    = ex_alu_src_q;
    assign ex_alu_op     = ex_alu_op_q;
    assign bubble_cnt    = bubble_cnt_q;

endmodule
